baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
- Parametrised fractional baud-rate generator; successor to the fixed-divide toggling baud clock.
- Emits single-cycle clock-enable pulses, not a derived clock:
  - oversample tick for the UART receiver;
  - bit tick for the UART transmitter;
  - mid-bit sample tick.
- Divisor is runtime-programmable (integer + fractional part); sits between the register bank and the UART TX/RX cores.

Parameters:
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle).
- OVS, 16, oversample ticks per bit; power of two, ≥4.
- DEF_INT, 325, integer divisor after reset (50 MHz / (16×9600)).
- DEF_FRAC, 8, fractional divisor after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; low freezes all state
- div_load  in  1  one-cycle strobe; capture div_int/div_frac and restart
- div_int  in  DIV_W  integer cycles per oversample tick
- div_frac  in  FRAC_W  fractional cycles per oversample tick
- tick_ovs  out  1  one-cycle pulse per oversample period
- tick_bit  out  1  one-cycle pulse every OVS oversample ticks
- tick_mid  out  1  one-cycle pulse at oversample tick OVS/2 of each bit
- ovs_idx  out  log2(OVS)  current oversample index within bit

Behaviour:
- Reset (async, active-high):
  - cnt, acc and ovs_idx cleared to 0.
  - Active divisor registers = DEF_INT/DEF_FRAC.
  - All tick outputs 0.
- Active divisor: div_int_r, div_frac_r.
  - Effective integer divisor: I = max(div_int_r, 1). div_int=0 is treated as 1.
  - Carry c = (acc + div_frac_r ≥ 2^FRAC_W).
  - Current period P = I + c; acc is constant within a period.
- Each cycle with en=1 and no div_load:
  - If cnt == P-1:
    - cnt←0.
    - acc←(acc+div_frac_r) mod 2^FRAC_W.
    - ovs_idx←ovs_idx+1 (wraps OVS-1→0).
    - tick_ovs←1 in the next cycle.
  - Else: cnt←cnt+1.
- Derived ticks:
  - tick_bit←1 on the same terminal event when ovs_idx == OVS-1.
  - tick_mid←1 on the same terminal event when ovs_idx == OVS/2-1.
- All tick outputs are registered: the pulse appears the cycle after the terminal count and lasts exactly one cycle.
- Latency from restart:
  - First tick_ovs at cycle P after the first enabled cycle.
  - First tick_bit after the sum of OVS periods.
- en=0: cnt, acc and ovs_idx hold; tick outputs 0. Resuming continues the partial period with no lost or extra cycles.
- div_load=1 (priority over en, acts regardless of en):
  - Loads div_int_r/div_frac_r.
  - Clears cnt, acc and ovs_idx.
  - Forces tick outputs 0 in the next cycle.
  - New period starts the following cycle.
- Long-run average period per tick_ovs = I + div_frac_r/2^FRAC_W cycles, exact over every 2^FRAC_W ticks.
- cnt width DIV_W+1; no overflow for any legal input.
- Reset asserted mid-period aborts immediately; no pulse is emitted during or on the release of reset.

Optional Feature:
- BAUD_TICK_FRAC_EN defined:
  - Fractional accumulator present, behaviour as above.
- BAUD_TICK_FRAC_EN undefined:
  - acc and div_frac_r removed; div_frac port present but ignored.
  - P = I always; DEF_FRAC unused.

Decomposition:
- Shared package baud_pkg holds:
  - DIV_W, FRAC_W, OVS defaults;
  - DEF_INT/DEF_FRAC constants;
  - localparam OVS_W = log2(OVS);
  - a divisor struct type {int, frac}, also used by the register bank.
- One natural sub-module: baud_frac_acc.
  - Holds acc and computes carry c.
  - Advances acc on the terminal-count strobe.
  - Instantiated only under BAUD_TICK_FRAC_EN.

Test Plan:
- Reset values: after reset, div=325/8 and en=1 → tick_ovs spacing alternates 325/326 cycles, exactly 8 periods of 326 per 16 ticks; tick_bit every 16 tick_ovs, i.e. 5208 cycles per bit.
- Integer only: div_load with div_int=4, div_frac=0 →
  - tick_ovs at cycles 4, 8, 12… after load;
  - tick_mid on the 8th tick_ovs; tick_bit on the 16th (cycle 64).
- Minimum divisor: div_int=0 (and 1), frac=0 → tick_ovs high every cycle after the first; tick_bit every 16 cycles.
- Enable gating: div_int=10; drop en for 7 cycles at cnt=5 → next tick_ovs delayed by exactly 7 cycles; no pulse while en=0.
- Reload mid-bit: at ovs_idx=9, div_load with div_int=3 and en=1 in the same cycle → ovs_idx=0; first tick_ovs 3 cycles after restart; tick_bit 48 cycles after restart.
- Async reset mid-period: assert reset between clock edges → all outputs 0 immediately; after release, first tick_ovs after 325 or 326 cycles per the DEF_FRAC sequence, starting from acc=0.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants and divisor type for the baud tick generator and the register bank.
package baud_pkg;

  localparam int BAUD_DIV_W    = 16;
  localparam int BAUD_FRAC_W   = 4;
  localparam int BAUD_OVS      = 16;
  localparam int BAUD_DEF_INT  = 325;
  localparam int BAUD_DEF_FRAC = 8;
  localparam int OVS_W         = $clog2(BAUD_OVS);

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } baud_div_t;

  function automatic baud_div_t baud_div_default();
    baud_div_t d;
    d.div_int  = BAUD_DIV_W'(BAUD_DEF_INT);
    d.div_frac = BAUD_FRAC_W'(BAUD_DEF_FRAC);
    return d;
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: holds the active fractional divisor and acc,
// and reports whether the current oversample period needs one extra cycle.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int FRAC_W   = BAUD_FRAC_W,
  parameter int DEF_FRAC = BAUD_DEF_FRAC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              adv_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum_s;

  assign sum_s   = {1'b0, acc_q} + {1'b0, frac_q};
  assign carry_o = sum_s[FRAC_W];

  always_comb begin
    frac_d = frac_q;
    acc_d  = acc_q;
    if (load_i) begin
      frac_d = div_frac_i;
      acc_d  = '0;
    end else if (adv_i) begin
      acc_d = sum_s[FRAC_W-1:0];
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frac_q <= FRAC_W'(DEF_FRAC);
      acc_q  <= '0;
    end else begin
      frac_q <= frac_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate generator emitting oversample, bit and mid-bit enable pulses.
// Define BAUD_TICK_FRAC_EN to include the fractional accumulator; otherwise P = I.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_W    = BAUD_DIV_W,
  parameter int FRAC_W   = BAUD_FRAC_W,
  parameter int OVS      = BAUD_OVS,
  parameter int DEF_INT  = BAUD_DEF_INT,
  parameter int DEF_FRAC = BAUD_DEF_FRAC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    div_load,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    tick_ovs,
  output logic                    tick_bit,
  output logic                    tick_mid,
  output logic [$clog2(OVS)-1:0]  ovs_idx
);

  localparam int IDX_W = $clog2(OVS);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_MID = IDX_W'(OVS / 2 - 1);
  localparam logic [DIV_W:0]   CNT_ONE = {{DIV_W{1'b0}}, 1'b1};

  logic [DIV_W-1:0] div_int_q, div_int_d;
  logic [DIV_W:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovs_q, ovs_d;
  logic             bit_q, bit_d;
  logic             mid_q, mid_d;

  logic [DIV_W-1:0] i_eff_s;
  logic [DIV_W:0]   period_s;
  logic             carry_s;
  logic             term_s;
  logic             adv_s;

  // A zero integer divisor behaves as one so the counter always terminates.
  assign i_eff_s  = (div_int_q == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div_int_q;
  assign period_s = {1'b0, i_eff_s} + {{DIV_W{1'b0}}, carry_s};
  assign term_s   = (cnt_q == (period_s - CNT_ONE));
  assign adv_s    = en & ~div_load & term_s;

`ifdef BAUD_TICK_FRAC_EN
  baud_frac_acc #(
    .FRAC_W   (FRAC_W),
    .DEF_FRAC (DEF_FRAC)
  ) u_frac_acc (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load),
    .div_frac_i (div_frac),
    .adv_i      (adv_s),
    .carry_o    (carry_s)
  );
`else
  logic [FRAC_W-1:0] unused_frac_s;
  assign unused_frac_s = div_frac ^ FRAC_W'(DEF_FRAC);
  assign carry_s       = 1'b0;
`endif

  always_comb begin
    div_int_d = div_int_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ovs_d     = 1'b0;
    bit_d     = 1'b0;
    mid_d     = 1'b0;
    if (div_load) begin
      div_int_d = div_int;
      cnt_d     = '0;
      idx_d     = '0;
    end else if (en) begin
      if (term_s) begin
        cnt_d = '0;
        idx_d = idx_q + IDX_W'(1);
        ovs_d = 1'b1;
        bit_d = (idx_q == IDX_MAX);
        mid_d = (idx_q == IDX_MID);
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_int_q <= DIV_W'(DEF_INT);
      cnt_q     <= '0;
      idx_q     <= '0;
      ovs_q     <= 1'b0;
      bit_q     <= 1'b0;
      mid_q     <= 1'b0;
    end else begin
      div_int_q <= div_int_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ovs_q     <= ovs_d;
      bit_q     <= bit_d;
      mid_q     <= mid_d;
    end
  end

  assign tick_ovs = ovs_q;
  assign tick_bit = bit_q;
  assign tick_mid = mid_q;
  assign ovs_idx  = idx_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: arithmetic period model plus directed latency checks.
module tb_baud_tick_gen;

  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OVS      = 16;
  localparam int DEF_INT  = 325;
  localparam int DEF_FRAC = 8;
  localparam int FMOD     = 1 << FRAC_W;
`ifdef BAUD_TICK_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              en;
  logic              div_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              tick_ovs;
  logic              tick_bit;
  logic              tick_mid;
  logic [3:0]        ovs_idx;

  int errors = 0;
  int checks = 0;

  baud_tick_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_load (div_load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .tick_ovs (tick_ovs),
    .tick_bit (tick_bit),
    .tick_mid (tick_mid),
    .ovs_idx  (ovs_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Length of the k-th oversample period after a restart: acc before it is k*F mod 2^FRAC_W.
  function automatic int mperiod(input int i, input int f, input int k);
    int ie;
    int a;
    ie = (i == 0) ? 1 : i;
    if (!FRAC_ON) return ie;
    a = ((k % FMOD) * f) % FMOD;
    return ie + (((a + f) >= FMOD) ? 1 : 0);
  endfunction

  int m_i, m_f, m_k, m_e;
  bit m_ovs, m_bit, m_mid;

  // Reference: count enabled cycles inside the current period and ticks since restart.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_i <= DEF_INT; m_f <= DEF_FRAC; m_k <= 0; m_e <= 0;
      m_ovs <= 1'b0; m_bit <= 1'b0; m_mid <= 1'b0;
    end else if (div_load) begin
      m_i <= int'(div_int); m_f <= int'(div_frac); m_k <= 0; m_e <= 0;
      m_ovs <= 1'b0; m_bit <= 1'b0; m_mid <= 1'b0;
    end else if (en) begin
      if (m_e + 1 == mperiod(m_i, m_f, m_k)) begin
        m_ovs <= 1'b1;
        m_bit <= ((m_k % OVS) == OVS - 1);
        m_mid <= ((m_k % OVS) == OVS / 2 - 1);
        m_k   <= m_k + 1;
        m_e   <= 0;
      end else begin
        m_e <= m_e + 1;
        m_ovs <= 1'b0; m_bit <= 1'b0; m_mid <= 1'b0;
      end
    end else begin
      m_ovs <= 1'b0; m_bit <= 1'b0; m_mid <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    check("m_tick_ovs", int'(tick_ovs), int'(m_ovs));
    check("m_tick_bit", int'(tick_bit), int'(m_bit));
    check("m_tick_mid", int'(tick_mid), int'(m_mid));
    check("m_ovs_idx",  int'(ovs_idx),  m_k % OVS);
  end

  task automatic wait_ovs(output int n, input int lim);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_ovs && n < lim);
    if (!tick_ovs) check("timeout_ovs", 0, 1);
  endtask

  task automatic wait_bit(output int n, input int lim);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_bit && n < lim);
    if (!tick_bit) check("timeout_bit", 0, 1);
  endtask

  task automatic do_load(input int i, input int f);
    div_load = 1'b1;
    div_int  = DIV_W'(i);
    div_frac = FRAC_W'(f);
    @(negedge clk);
    div_load = 1'b0;
  endtask

  initial begin
    int n, sum, n326, f, lim;
    reset = 1'b1; en = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk);
    check("rst_tick_ovs", int'(tick_ovs), 0);
    check("rst_ovs_idx", int'(ovs_idx), 0);
    reset = 1'b0;
    en = 1'b1;

    // Default divisor 325 + 8/16.
    sum = 0; n326 = 0;
    for (int t = 1; t <= 16; t++) begin
      wait_ovs(n, 400);
      sum += n;
      if (n == 326) n326++;
      if (t == 1) check("def_first_period", n, 325);
      if (t == 2) check("def_second_period", n, FRAC_ON ? 326 : 325);
      if (t == 16) check("def_bit_on_16th", int'(tick_bit), 1);
    end
    check("def_bit_cycles", sum, FRAC_ON ? 5208 : 5200);
    check("def_n326", n326, FRAC_ON ? 8 : 0);

    // Integer divisor 4.
    do_load(4, 0);
    sum = 0;
    for (int t = 1; t <= 16; t++) begin
      wait_ovs(n, 20);
      sum += n;
      if (t == 1) check("int4_first", n, 4);
      if (t == 8) check("int4_mid_on_8th", int'(tick_mid), 1);
      if (t == 16) check("int4_bit_on_16th", int'(tick_bit), 1);
    end
    check("int4_bit_cycle", sum, 64);

    // Minimum divisor: 0 and 1 both give one-cycle periods.
    do_load(0, 0);
    wait_ovs(n, 5);
    check("div0_first", n, 1);
    wait_bit(n, 40);
    wait_bit(n, 40);
    check("div0_bit_spacing", n, 16);
    do_load(1, 0);
    wait_ovs(n, 5);
    check("div1_first", n, 1);
    repeat (5) begin
      @(negedge clk);
      check("div1_continuous", int'(tick_ovs), 1);
    end

    // Enable gating at cnt=5 for 7 cycles.
    do_load(10, 0);
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (7) begin
      @(negedge clk);
      check("gate_no_pulse", int'(tick_ovs), 0);
    end
    en = 1'b1;
    wait_ovs(n, 30);
    check("gate_total_delay", n + 12, 17);

    // Reload mid-bit at ovs_idx=9.
    do_load(4, 0);
    lim = 0;
    while (ovs_idx != 4'd9 && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    check("reload_reached_idx9", int'(ovs_idx), 9);
    do_load(3, 0);
    check("reload_idx_cleared", int'(ovs_idx), 0);
    wait_ovs(n, 10);
    check("reload_first", n, 3);
    wait_bit(sum, 100);
    check("reload_bit", n + sum, 48);

    // Async reset between clock edges.
    do_load(7, 0);
    repeat (23) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_tick_ovs", int'(tick_ovs), 0);
    check("areset_ovs_idx", int'(ovs_idx), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ovs(n, 400);
    check("areset_first", n, 325);

    // Long-run average: 16 periods sum to 16*I + F.
    f = int'($urandom_range(1, 15));
    do_load(5, f);
    sum = 0;
    for (int t = 0; t < 16; t++) begin
      wait_ovs(n, 20);
      sum += n;
    end
    check("avg_16_periods", sum, FRAC_ON ? 80 + f : 80);

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) begin
        div_load = 1'b1;
        div_int  = DIV_W'($urandom_range(0, 6));
        div_frac = FRAC_W'($urandom_range(0, 15));
      end else begin
        div_load = 1'b0;
      end
      @(negedge clk);
    end
    div_load = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
